control_stage: RTL and testbench

Registered decode stage for the 5-stage RISC-V pipeline. It decodes the ID-stage opcode into the control bundle and holds that bundle in its own ID/EX control register. It also detects load-use hazards against the instruction currently in EX and inserts a parametrised number of bubbles, driving the fetch/IF-ID stall line. It supersedes the combinational decoder by adding I-type ALU decode, a branch ALU mode, an x0 write guard and a multi-cycle stall FSM.

---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/control_stage_if.sv | 35 +++
 rtl/control_stage_decode.sv | 48 ++++
 rtl/control_stage.sv | 110 +++++++++++
 tb/tb_control_stage.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode constants, ALU-mode encodings, control bundle type and FSM
// state encoding for the registered decode stage.
package ctrl_pkg;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [1:0] ALUOP_RTYPE  = 2'b00;
   localparam logic [1:0] ALUOP_IMM    = 2'b01;
   localparam logic [1:0] ALUOP_BRANCH = 2'b10;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } stage_state_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       alu_src;
      logic [1:0] alu_op;
   } ctrl_bundle_t;

endpackage

// File: rtl/control_stage_if.sv
// ID-stage instruction fields in, ID/EX control bundle and stall/trap lines out.
interface control_stage_if #(
   parameter int unsigned ALUOP_W    = 2,
   parameter int unsigned REG_ADDR_W = 5
);
   logic [6:0]            Op_i;
   logic                  NoOp_i;
   logic                  Flush_i;
   logic [REG_ADDR_W-1:0] RS1addr_i;
   logic [REG_ADDR_W-1:0] RS2addr_i;
   logic [REG_ADDR_W-1:0] RDaddr_i;

   logic                  RegWrite_o;
   logic                  MemToReg_o;
   logic                  MemRead_o;
   logic                  MemWrite_o;
   logic                  Branch_o;
   logic                  ALUSrc_o;
   logic [ALUOP_W-1:0]    ALUOp_o;
   logic [REG_ADDR_W-1:0] RDaddr_o;
   logic                  Stall_o;
   logic                  Illegal_o;

   modport master (
      output Op_i, NoOp_i, Flush_i, RS1addr_i, RS2addr_i, RDaddr_i,
      input  RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o, ALUSrc_o,
             ALUOp_o, RDaddr_o, Stall_o, Illegal_o
   );

   modport slave (
      input  Op_i, NoOp_i, Flush_i, RS1addr_i, RS2addr_i, RDaddr_i,
      output RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o, ALUSrc_o,
             ALUOp_o, RDaddr_o, Stall_o, Illegal_o
   );
endinterface

// File: rtl/control_stage_decode.sv
// Combinational opcode decode: control bundle, rs2-usage and illegal-opcode flag.
module control_decode
   import ctrl_pkg::*;
(
   input  logic [6:0]   i_op,
   output ctrl_bundle_t o_ctrl,
   output logic         o_uses_rs2,
   output logic         o_illegal
);

   always_comb begin
      o_ctrl     = '0;
      o_uses_rs2 = 1'b0;
      o_illegal  = 1'b0;
      case (i_op)
         OP_RTYPE: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.alu_op    = ALUOP_RTYPE;
            o_uses_rs2       = 1'b1;
         end
         OP_IALU: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.alu_src   = 1'b1;
            o_ctrl.alu_op    = ALUOP_IMM;
         end
         OP_LW: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
            o_ctrl.mem_read   = 1'b1;
            o_ctrl.alu_src    = 1'b1;
            o_ctrl.alu_op     = ALUOP_IMM;
         end
         OP_SW: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.alu_src   = 1'b1;
            o_ctrl.alu_op    = ALUOP_IMM;
            o_uses_rs2       = 1'b1;
         end
         OP_BEQ: begin
            o_ctrl.branch = 1'b1;
            o_ctrl.alu_op = ALUOP_BRANCH;
            o_uses_rs2    = 1'b1;
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_stage.sv
// Registered ID/EX decode stage with load-use bubble FSM.
// Optional sticky illegal-opcode trap enabled by defining CTRL_ILLEGAL_TRAP_EN.
module control_stage
   import ctrl_pkg::*;
#(
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned ALUOP_W           = 2,
   parameter int unsigned REG_ADDR_W        = 5
) (
   input logic             clk_i,
   input logic             rst_i,
   control_stage_if.slave  bus
);

   localparam int unsigned      CNT_W      = $clog2(LOAD_STALL_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);

   stage_state_e          r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   ctrl_bundle_t          r_ctrl, w_ctrl_nxt, w_dec;
   logic [REG_ADDR_W-1:0] r_rd, w_rd_nxt;
   logic                  w_uses_rs2, w_illegal, w_hazard, w_stall;

   control_decode u_decode (
      .i_op       (bus.Op_i),
      .o_ctrl     (w_dec),
      .o_uses_rs2 (w_uses_rs2),
      .o_illegal  (w_illegal)
   );

   assign w_hazard = (r_state == ST_RUN) && !bus.NoOp_i && !bus.Flush_i &&
                     r_ctrl.mem_read && (r_rd != '0) &&
                     ((r_rd == bus.RS1addr_i) || (w_uses_rs2 && (r_rd == bus.RS2addr_i)));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ctrl_nxt  = '0;
      w_rd_nxt    = '0;
      w_stall     = 1'b0;
      if (bus.Flush_i) begin
         w_state_nxt = ST_RUN;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_hazard) begin
                  w_stall = 1'b1;
                  // A single-bubble hazard completes in RUN; STALL covers the rest.
                  if (LOAD_STALL_CYCLES > 1) begin
                     w_state_nxt = ST_STALL;
                     w_cnt_nxt   = CNT_RELOAD;
                  end
               end else if (!bus.NoOp_i && !w_illegal) begin
                  w_ctrl_nxt = w_dec;
                  w_rd_nxt   = bus.RDaddr_i;
                  if (bus.RDaddr_i == '0) w_ctrl_nxt.reg_write = 1'b0;
               end
            end
            ST_STALL: begin
               w_stall   = 1'b1;
               w_cnt_nxt = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) w_state_nxt = ST_RUN;
            end
            default: begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_RUN;
         r_cnt   <= '0;
         r_ctrl  <= '0;
         r_rd    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ctrl  <= w_ctrl_nxt;
         r_rd    <= w_rd_nxt;
      end
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic r_illegal;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                                         r_illegal <= 1'b0;
      else if (w_illegal && !bus.NoOp_i && !bus.Flush_i) r_illegal <= 1'b1;
   end

   assign bus.Illegal_o = r_illegal;
`else
   assign bus.Illegal_o = 1'b0;
`endif

   assign bus.RegWrite_o = r_ctrl.reg_write;
   assign bus.MemToReg_o = r_ctrl.mem_to_reg;
   assign bus.MemRead_o  = r_ctrl.mem_read;
   assign bus.MemWrite_o = r_ctrl.mem_write;
   assign bus.Branch_o   = r_ctrl.branch;
   assign bus.ALUSrc_o   = r_ctrl.alu_src;
   assign bus.ALUOp_o    = ALUOP_W'(r_ctrl.alu_op);
   assign bus.RDaddr_o   = r_rd;
   assign bus.Stall_o    = w_stall;

endmodule

// File: tb/tb_control_stage.sv
// Bench for control_stage: two instances (1 and 3 bubbles per load-use) checked
// every cycle against a pending-bubble model, plus hand-computed expectations.
module tb_control_stage;

   typedef struct packed {
      logic [6:0] op;
      logic       noop;
      logic       flush;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } instr_t;

   typedef struct packed {
      logic       rw, mtr, mr, mw, br, src;
      logic [1:0] alu;
      logic [4:0] rd;
   } exp_t;

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam logic ILL_EXP = 1'b1;
`else
   localparam logic ILL_EXP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   control_stage_if #(.ALUOP_W(2), .REG_ADDR_W(5)) if0 ();
   control_stage_if #(.ALUOP_W(2), .REG_ADDR_W(5)) if1 ();

   control_stage #(.LOAD_STALL_CYCLES(1), .ALUOP_W(2), .REG_ADDR_W(5)) dut0 (
      .clk_i(clk), .rst_i(rst_n), .bus(if0));
   control_stage #(.LOAD_STALL_CYCLES(3), .ALUOP_W(2), .REG_ADDR_W(5)) dut1 (
      .clk_i(clk), .rst_i(rst_n), .bus(if1));

   int          passed = 0;
   int          total  = 0;
   instr_t      cur   [2];
   exp_t        m_out [2];
   int          pend  [2];
   logic        m_ill [2];
   int          lp    [2] = '{1, 3};
   exp_t        act   [2];
   logic        stall_act [2];
   logic        ill_act   [2];

   always_comb begin
      act[0] = '{if0.RegWrite_o, if0.MemToReg_o, if0.MemRead_o, if0.MemWrite_o,
                 if0.Branch_o, if0.ALUSrc_o, if0.ALUOp_o, if0.RDaddr_o};
      act[1] = '{if1.RegWrite_o, if1.MemToReg_o, if1.MemRead_o, if1.MemWrite_o,
                 if1.Branch_o, if1.ALUSrc_o, if1.ALUOp_o, if1.RDaddr_o};
      stall_act[0] = if0.Stall_o;
      stall_act[1] = if1.Stall_o;
      ill_act[0]   = if0.Illegal_o;
      ill_act[1]   = if1.Illegal_o;
   end

   function automatic instr_t mk(logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2,
                                 logic [4:0] rd, logic flush);
      instr_t x;
      x.op = op; x.noop = 1'b0; x.flush = flush; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
      return x;
   endfunction

   function automatic instr_t bub();
      instr_t x = '0;
      x.noop = 1'b1;
      return x;
   endfunction

   // Model: what each opcode means architecturally.
   function automatic exp_t decode_exp(instr_t x);
      exp_t e = '0;
      case (x.op)
         7'b0110011: begin e.rw = 1; e.alu = 2'd0; e.rd = x.rd; end
         7'b0010011: begin e.rw = 1; e.src = 1; e.alu = 2'd1; e.rd = x.rd; end
         7'b0000011: begin e.rw = 1; e.mtr = 1; e.mr = 1; e.src = 1; e.alu = 2'd1; e.rd = x.rd; end
         7'b0100011: begin e.mw = 1; e.src = 1; e.alu = 2'd1; e.rd = x.rd; end
         7'b1100011: begin e.br = 1; e.alu = 2'd2; e.rd = x.rd; end
         default: e = '0;
      endcase
      if (x.rd == 5'd0) e.rw = 1'b0;
      return e;
   endfunction

   function automatic logic is_legal(logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
   endfunction

   function automatic logic model_haz(int d);
      instr_t x = cur[d];
      logic   reads_rs2 = x.op inside {7'b0110011, 7'b0100011, 7'b1100011};
      return !x.noop && !x.flush && pend[d] == 0 && m_out[d].mr && m_out[d].rd != 5'd0 &&
             (m_out[d].rd == x.rs1 || (reads_rs2 && m_out[d].rd == x.rs2));
   endfunction

   function automatic logic model_stall(int d);
      if (cur[d].flush) return 1'b0;
      if (pend[d] > 0) return 1'b1;
      return model_haz(d);
   endfunction

   task automatic model_update();
      for (int d = 0; d < 2; d++) begin
         logic h = model_haz(d);
         if (ILL_EXP && !cur[d].noop && !cur[d].flush && !is_legal(cur[d].op)) m_ill[d] = 1'b1;
         if (cur[d].flush) begin
            m_out[d] = '0; pend[d] = 0;
         end else if (pend[d] > 0) begin
            m_out[d] = '0; pend[d] = pend[d] - 1;
         end else if (h) begin
            m_out[d] = '0; pend[d] = lp[d] - 1;
         end else if (cur[d].noop) begin
            m_out[d] = '0;
         end else begin
            m_out[d] = decode_exp(cur[d]);
         end
      end
   endtask

   task automatic chk(string name, int d, logic [31:0] a, logic [31:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s dut%0d: got %0h expected %0h", name, d, a, e);
   endtask

   task automatic compare();
      for (int d = 0; d < 2; d++) begin
         chk("stall",   d, 32'(stall_act[d]), 32'(model_stall(d)));
         chk("idex",    d, 32'(act[d]),       32'(m_out[d]));
         chk("illegal", d, 32'(ill_act[d]),   32'(m_ill[d]));
      end
   endtask

   task automatic drive_all();
      if0.Op_i = cur[0].op; if0.NoOp_i = cur[0].noop; if0.Flush_i = cur[0].flush;
      if0.RS1addr_i = cur[0].rs1; if0.RS2addr_i = cur[0].rs2; if0.RDaddr_i = cur[0].rd;
      if1.Op_i = cur[1].op; if1.NoOp_i = cur[1].noop; if1.Flush_i = cur[1].flush;
      if1.RS1addr_i = cur[1].rs1; if1.RS2addr_i = cur[1].rs2; if1.RDaddr_i = cur[1].rd;
   endtask

   task automatic step(input int s, input instr_t ins, output logic st);
      cur[0] = bub(); cur[1] = bub(); cur[s] = ins;
      drive_all();
      @(negedge clk);
      compare();
      st = stall_act[s];
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic issue(input int s, input instr_t ins, output int n);
      logic st;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         step(s, ins, st);
         if (!st) return;
         n++;
      end
      total++;
      $display("FAIL issue_timeout dut%0d: stall still 1 after 10 cycles, required 0", s);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         m_out[d] = '0; pend[d] = 0; m_ill[d] = 1'b0;
      end
      @(negedge clk);
      compare();
      chk("rst_stall", 1, 32'(if1.Stall_o),  32'd0);
      chk("rst_rd",    1, 32'(if1.RDaddr_o), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   localparam logic [6:0] LW = 7'b0000011, ADD = 7'b0110011, ADDI = 7'b0010011,
                          SW = 7'b0100011, BEQ = 7'b1100011;

   initial begin
      int   n;
      logic st;
      cur[0] = bub(); cur[1] = bub();
      drive_all();
      do_reset();

      // LW x5 ; ADD x6,x5,x7 with one bubble
      issue(0, mk(LW, 5'd1, 5'd0, 5'd5, 1'b0), n);  chk("l1_lw_nostall", 0, n, 0);
      issue(0, mk(ADD, 5'd5, 5'd7, 5'd6, 1'b0), n); chk("l1_bubbles", 0, n, 1);
      chk("l1_add_rw", 0, 32'(if0.RegWrite_o), 32'd1);
      chk("l1_add_aluop", 0, 32'(if0.ALUOp_o), 32'd0);
      chk("l1_add_rd", 0, 32'(if0.RDaddr_o), 32'd6);

      // Same pair with three bubbles
      issue(1, mk(LW, 5'd1, 5'd0, 5'd5, 1'b0), n);
      issue(1, mk(ADD, 5'd5, 5'd7, 5'd6, 1'b0), n); chk("l3_bubbles", 1, n, 3);
      chk("l3_add_rd", 1, 32'(if1.RDaddr_o), 32'd6);

      // Dependent back-to-back loads, then consumer of the second load
      issue(1, mk(LW, 5'd1, 5'd0, 5'd5, 1'b0), n);
      issue(1, mk(LW, 5'd5, 5'd0, 5'd6, 1'b0), n); chk("l3_lwlw", 1, n, 3);
      issue(1, mk(ADD, 5'd6, 5'd6, 5'd7, 1'b0), n); chk("l3_lwlw_add", 1, n, 3);

      // No-hazard cases: x0 destination, and I-type whose rs2 field aliases
      issue(0, mk(LW, 5'd1, 5'd0, 5'd0, 1'b0), n);
      issue(0, mk(ADD, 5'd0, 5'd0, 5'd1, 1'b0), n); chk("x0_nostall", 0, n, 0);
      issue(1, mk(LW, 5'd1, 5'd0, 5'd5, 1'b0), n);
      issue(1, mk(ADDI, 5'd7, 5'd5, 5'd6, 1'b0), n); chk("addi_rs2_nostall", 1, n, 0);
      chk("addi_alusrc", 1, 32'(if1.ALUSrc_o), 32'd1);

      // rs2 consumers SW and BEQ
      issue(0, mk(LW, 5'd1, 5'd0, 5'd5, 1'b0), n);
      issue(0, mk(SW, 5'd1, 5'd5, 5'd3, 1'b0), n);  chk("sw_rs2_haz", 0, n, 1);
      issue(0, mk(LW, 5'd1, 5'd0, 5'd5, 1'b0), n);
      issue(0, mk(BEQ, 5'd2, 5'd5, 5'd4, 1'b0), n); chk("beq_rs2_haz", 0, n, 1);
      chk("beq_aluop", 0, 32'(if0.ALUOp_o), 32'd2);

      // Flush on the hazard cycle
      issue(1, mk(LW, 5'd1, 5'd0, 5'd5, 1'b0), n);
      step(1, mk(ADD, 5'd5, 5'd7, 5'd6, 1'b1), st);  chk("flush_stall", 1, 32'(st), 32'd0);
      chk("flush_bubble", 1, 32'(if1.MemRead_o), 32'd0);
      issue(1, mk(ADD, 5'd5, 5'd7, 5'd6, 1'b0), n);  chk("flush_next", 1, n, 0);

      // Flush while already in the multi-cycle stall
      issue(1, mk(LW, 5'd1, 5'd0, 5'd5, 1'b0), n);
      step(1, mk(ADD, 5'd5, 5'd7, 5'd6, 1'b0), st);
      step(1, mk(ADD, 5'd5, 5'd7, 5'd6, 1'b1), st);  chk("flush_in_stall", 1, 32'(st), 32'd0);
      issue(1, mk(ADD, 5'd5, 5'd7, 5'd6, 1'b0), n);  chk("flush_in_stall_next", 1, n, 0);

      // NoOp during STALL leaves the bubble count alone
      issue(1, mk(LW, 5'd1, 5'd0, 5'd5, 1'b0), n);
      n = 0;
      step(1, mk(ADD, 5'd5, 5'd7, 5'd6, 1'b0), st); n += int'(st);
      step(1, bub(), st); n += int'(st);
      step(1, bub(), st); n += int'(st);
      chk("noop_in_stall", 1, n, 3);
      issue(1, mk(ADD, 5'd5, 5'd7, 5'd6, 1'b0), n);  chk("noop_in_stall_next", 1, n, 0);

      // Asynchronous reset on the second stall cycle
      issue(1, mk(LW, 5'd1, 5'd0, 5'd5, 1'b0), n);
      step(1, mk(ADD, 5'd5, 5'd7, 5'd6, 1'b0), st);
      step(1, mk(ADD, 5'd5, 5'd7, 5'd6, 1'b0), st);
      do_reset();
      issue(1, mk(ADD, 5'd5, 5'd7, 5'd6, 1'b0), n);  chk("post_rst_nostall", 1, n, 0);
      chk("post_rst_rw", 1, 32'(if1.RegWrite_o), 32'd1);
      chk("post_rst_rd", 1, 32'(if1.RDaddr_o), 32'd6);

      // Undecodable opcode
      issue(0, mk(7'b1111111, 5'd2, 5'd3, 5'd4, 1'b0), n);
      chk("ill_flag", 0, 32'(if0.Illegal_o), 32'(ILL_EXP));
      chk("ill_bubble_rw", 0, 32'(if0.RegWrite_o), 32'd0);
      chk("ill_bubble_rd", 0, 32'(if0.RDaddr_o), 32'd0);
      issue(0, mk(ADD, 5'd1, 5'd2, 5'd3, 1'b0), n);
      chk("ill_sticky", 0, 32'(if0.Illegal_o), 32'(ILL_EXP));
      do_reset();
      chk("ill_cleared", 0, 32'(if0.Illegal_o), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
